// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit with HI/LO result registers.
// The result is computed from the operands sampled at the start edge and held
// in pending registers until the busy countdown expires, then copied to HI/LO.
// Optional macro MDU_MADD_EN enables madd/maddu/msub/msubu on ops 4-7.
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count, count_next;
  logic [WIDTH-1:0]   pend_hi, pend_hi_next;
  logic [WIDTH-1:0]   pend_lo, pend_lo_next;
  logic               pend_valid, pend_valid_next;
  logic [WIDTH-1:0]   hi_next, lo_next;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   div_q, div_r;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_valid, op_legal, op_div;

  assign busy = (state == RUN);

  // Full-width products; sign extension to 2W bits gives the signed product modulo 2^(2W)
  always_comb begin
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

  // Divide on magnitudes, then restore signs (quotient toward zero, remainder follows dividend)
  always_comb begin
    logic             is_signed, neg_a, neg_b;
    logic [WIDTH-1:0] dvd, dvs, q_mag, r_mag;
    is_signed = ~op[0];
    neg_a     = is_signed & a[WIDTH-1];
    neg_b     = is_signed & b[WIDTH-1];
    dvd       = neg_a ? (~a + 1'b1) : a;
    dvs       = neg_b ? (~b + 1'b1) : b;
    if (b == '0) dvs = {{(WIDTH-1){1'b0}}, 1'b1};
    q_mag     = dvd / dvs;
    r_mag     = dvd % dvs;
    div_q     = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
    div_r     = neg_a ? (~r_mag + 1'b1) : r_mag;
  end

  // Decode op into legality, latency class and the result to park in the pending registers
  always_comb begin
    res_hi    = '0;
    res_lo    = '0;
    res_valid = 1'b1;
    op_legal  = 1'b0;
    op_div    = 1'b0;
    case (op)
      3'd0: begin
        op_legal         = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      3'd1: begin
        op_legal         = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      3'd2, 3'd3: begin
        op_legal  = 1'b1;
        op_div    = 1'b1;
        res_hi    = div_r;
        res_lo    = div_q;
        res_valid = (b != '0);
      end
`ifdef MDU_MADD_EN
      3'd4: begin
        op_legal         = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_s;
      end
      3'd5: begin
        op_legal         = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_u;
      end
      3'd6: begin
        op_legal         = 1'b1;
        {res_hi, res_lo} = {hi, lo} - prod_s;
      end
      3'd7: begin
        op_legal         = 1'b1;
        {res_hi, res_lo} = {hi, lo} - prod_u;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic: launch from IDLE (start beats HI/LO writes), count down in RUN
  always_comb begin
    state_next      = state;
    count_next      = count;
    pend_hi_next    = pend_hi;
    pend_lo_next    = pend_lo;
    pend_valid_next = pend_valid;
    hi_next         = hi;
    lo_next         = lo;
    case (state)
      IDLE: begin
        if (start && op_legal) begin
          state_next      = RUN;
          count_next      = op_div ? DIV_LOAD : MULT_LOAD;
          pend_hi_next    = res_hi;
          pend_lo_next    = res_lo;
          pend_valid_next = res_valid;
        end else begin
          if (wr_hi) hi_next = wdata;
          if (wr_lo) lo_next = wdata;
        end
      end
      RUN: begin
        if (count == '0) begin
          state_next      = IDLE;
          pend_valid_next = 1'b0;
          if (pend_valid) begin
            hi_next = pend_hi;
            lo_next = pend_lo;
          end
        end else begin
          count_next = count - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and data registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_valid <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      pend_hi    <= pend_hi_next;
      pend_lo    <= pend_lo_next;
      pend_valid <= pend_valid_next;
      hi         <= hi_next;
      lo         <= lo_next;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b, wdata;
  logic        wr_hi, wr_lo;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Launch one op, then count busy cycles until completion (bounded)
  task automatic applyStimulus(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                               output int n_busy);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    tick();
    start = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    n_busy = 0;
    while (busy && n_busy < 200) begin
      n_busy++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wdata = '0;

    // Reset state, then 20 idle cycles
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_hi", hi, 32'h0);
    checkOutput("rst_lo", lo, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("idle_hi", hi, 32'h0);
      checkOutput("idle_lo", lo, 32'h0);
    end

    // mult -1 * 2
    applyStimulus(3'd0, 32'hFFFFFFFF, 32'd2, cycles);
    checkOutput("mult_cycles", cycles, 32'd5);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFFE);

    // multu 0xFFFFFFFF * 2
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'd2, cycles);
    checkOutput("multu_cycles", cycles, 32'd5);
    checkOutput("multu_hi", hi, 32'h00000001);
    checkOutput("multu_lo", lo, 32'hFFFFFFFE);

    // div -7 / 2
    applyStimulus(3'd2, 32'hFFFFFFF9, 32'd2, cycles);
    checkOutput("div_cycles", cycles, 32'd10);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);

    // divu 7 / 0 leaves HI/LO alone
    applyStimulus(3'd3, 32'd7, 32'd0, cycles);
    checkOutput("div0_cycles", cycles, 32'd10);
    checkOutput("div0_hi", hi, 32'hFFFFFFFF);
    checkOutput("div0_lo", lo, 32'hFFFFFFFD);

    // divu 100 / 7
    applyStimulus(3'd3, 32'd100, 32'd7, cycles);
    checkOutput("divu_hi", hi, 32'd2);
    checkOutput("divu_lo", lo, 32'd14);

    // div overflow case
    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, cycles);
    checkOutput("divovf_cycles", cycles, 32'd10);
    checkOutput("divovf_hi", hi, 32'h0);
    checkOutput("divovf_lo", lo, 32'h80000000);

    // start and wr_hi while busy are ignored
    start = 1'b1;
    op    = 3'd0;
    a     = 32'd3;
    b     = 32'd5;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    cycles = 1;
    start  = 1'b1;
    op     = 3'd2;
    a      = 32'd100;
    b      = 32'd7;
    wr_hi  = 1'b1;
    wdata  = 32'h1234;
    tick();
    start = 1'b0;
    wr_hi = 1'b0;
    while (busy && cycles < 200) begin
      cycles++;
      tick();
    end
    checkOutput("intrude_cycles", cycles, 32'd5);
    checkOutput("intrude_hi", hi, 32'h0);
    checkOutput("intrude_lo", lo, 32'd15);
    tick();
    checkOutput("intrude_noqueue", {31'd0, busy}, 32'd0);

    // start beats wr_lo in the same IDLE cycle
    wr_lo = 1'b1;
    wdata = 32'h1234;
    applyStimulus(3'd1, 32'd6, 32'd7, cycles);
    checkOutput("startwin_cycles", cycles, 32'd5);
    checkOutput("startwin_hi", hi, 32'h0);
    checkOutput("startwin_lo", lo, 32'd42);

    // wr_hi alone in IDLE
    wr_hi = 1'b1;
    wdata = 32'h1234;
    tick();
    wr_hi = 1'b0;
    checkOutput("mthi_hi", hi, 32'h1234);
    checkOutput("mthi_lo", lo, 32'd42);

    // wr_hi and wr_lo together
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = 32'hABCD;
    tick();
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    checkOutput("mthilo_hi", hi, 32'hABCD);
    checkOutput("mthilo_lo", lo, 32'hABCD);

    // Asynchronous reset during a div
    start = 1'b1;
    op    = 3'd2;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("prerst_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_hi", hi, 32'h0);
    checkOutput("midrst_lo", lo, 32'h0);
    tick();
    reset = 1'b1;
    applyStimulus(3'd0, 32'd3, 32'hFFFFFFFC, cycles);
    checkOutput("postrst_cycles", cycles, 32'd5);
    checkOutput("postrst_hi", hi, 32'hFFFFFFFF);
    checkOutput("postrst_lo", lo, 32'hFFFFFFF4);

    // Preload hi=0 lo=0xFFFFFFFF for the accumulate / reserved-op checks
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wdata = 32'h0;
    tick();
    wr_hi = 1'b0;
    wdata = 32'hFFFFFFFF;
    tick();
    wr_lo = 1'b0;
    checkOutput("preload_hi", hi, 32'h0);
    checkOutput("preload_lo", lo, 32'hFFFFFFFF);

`ifdef MDU_MADD_EN
    applyStimulus(3'd5, 32'd1, 32'd1, cycles);
    checkOutput("maddu_cycles", cycles, 32'd5);
    checkOutput("maddu_hi", hi, 32'h1);
    checkOutput("maddu_lo", lo, 32'h0);
    applyStimulus(3'd6, 32'd1, 32'd1, cycles);
    checkOutput("msub_hi", hi, 32'h0);
    checkOutput("msub_lo", lo, 32'hFFFFFFFF);
    applyStimulus(3'd4, 32'hFFFFFFFF, 32'd1, cycles);
    checkOutput("madd_hi", hi, 32'h0);
    checkOutput("madd_lo", lo, 32'hFFFFFFFE);
`else
    start = 1'b1;
    op    = 3'd4;
    a     = 32'd1;
    b     = 32'd1;
    tick();
    checkOutput("rsv4_busy", {31'd0, busy}, 32'd0);
    op = 3'd7;
    tick();
    start = 1'b0;
    checkOutput("rsv7_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("rsv_hi", hi, 32'h0);
    checkOutput("rsv_lo", lo, 32'hFFFFFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
